fp_cvt_lu_d_pipe: RTL
=====================

// Module: fp_cvt_lu_d_pipe
// PURPOSE
//  Converts IEEE 754 double (binary64) to 64-bit unsigned integer, RISC-V FCVT.LU.D semantics.
//  Inverse of the uint64->double converter in the D-extension ALU.
//  Two-stage valid/ready pipeline with per-op rounding mode; returns accrued fflags (NV, NX).
// PARAMETERS
//  TAG_W  4  width of opaque in_tag carried alongside each op to out_tag
// PORTS
//  clk         in   1      clock, all state on rising edge
//  rst_n       in   1      synchronous reset, active-low
//  in_valid    in   1      operand valid
//  in_ready    out  1      converter accepts op this cycle
//  in_d        in   64     binary64 operand
//  in_rm       in   3      rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM
//  in_tag      in   TAG_W  passthrough tag
//  out_valid   out  1      result valid
//  out_ready   in   1      consumer accepts result
//  out_lu      out  64     unsigned integer result
//  out_fflags  out  5      {NV,DZ,OF,UF,NX}; DZ/OF/UF always 0
//  out_tag     out  TAG_W  tag of this result
// BEHAVIOUR
//  Reset (rst_n=0 at edge): both stage valids clear; out_valid=0, out_lu=0, out_fflags=0, out_tag=0.
//  Reset mid-operation discards all in-flight ops; no result emitted for them.
//  Handshake: transfer when valid&&ready. out_valid/out_lu/out_fflags/out_tag stable while out_valid&&!out_ready.
//  Stage advance: s2 loads when s2 empty or out_ready; s1 loads when s1 empty or s1 advances.
//  in_ready = !s1_valid || s1_advance (combinational from out_ready; no bubble at full throughput).
//  Latency 2 cycles accept->out_valid; throughput 1 op/cycle with out_ready held high.
//  Stage 1 (classify/align): s=in_d[63], E=in_d[62:52], F=in_d[51:0], e=E-1023 (signed 12b).
//   NaN (E=7FF, F!=0) or +Inf: flag special_max. -Inf: flag special_neg.
//   E=0: int=0, guard=0, sticky=(F!=0).
//   e>=64: overflow. 52<=e<=63: int={1,F}<<(e-52), guard=sticky=0.
//   0<=e<=51: int={1,F}>>(52-e), guard=next bit below, sticky=OR of remaining bits.
//   e=-1: int=0, guard=1, sticky=(F!=0). e<=-2: int=0, guard=0, sticky=1.
//  Stage 2 (round/saturate), inexact = guard|sticky:
//   inc: RNE guard&(sticky|int[0]); RTZ 0; RDN s&inexact; RUP !s&inexact; RMM guard.
//   mag = int+inc (cannot carry out of 64 bits: e>=52 is always exact).
//   Reserved rm (101,110,111): round as RNE, no extra flag (illegal encodings trapped upstream).
//  Result/flag priority:
//   NaN, +Inf, +overflow -> out_lu=64'hFFFF_FFFF_FFFF_FFFF, NV=1, NX=0.
//   -Inf, -overflow      -> out_lu=0, NV=1, NX=0.
//   s=1, mag!=0          -> out_lu=0, NV=1, NX=0.
//   s=1, mag==0          -> out_lu=0, NV=0, NX=inexact (-0.0 exact: no flags).
//   s=0                  -> out_lu=mag, NV=0, NX=inexact.
//  Exactly one of NV/NX may be set per result; never both.
// STRUCTURE
//  Shared package fp_d_pkg: RM_RNE..RM_RMM encodings, FFLAG_NV/NX bit indices, DP_BIAS=1023,
//   DP_EXP_W=11, DP_FRAC_W=52, U64_MAX constant.
//  Top: handshake/pipeline regs + stage-1 classify/barrel shift.
//  Sub-module fp_cvt_lu_d_round: combinational stage-2 (inc select, add, saturation, flags).
// TESTING
//  1.0 (3FF0_0000_0000_0000), RNE -> out_lu=1, fflags=0, out_valid 2 cycles after accept.
//  2.5 (4004_0000_0000_0000): RNE -> 2 NX; RMM -> 3 NX; RUP -> 3 NX; RTZ -> 2 NX.
//  -0.5 (BFE0_...), RUP -> 0, NX only; RDN -> 0, NV; -1.0 (BFF0_...) RTZ -> 0, NV.
//  2^64 (43F0_...) -> FFFF_FFFF_FFFF_FFFF NV; 2^64-2048 (43EF_FFFF_FFFF_FFFF) -> FFFF_FFFF_FFFF_F800, no flags;
//   qNaN 7FF8_... -> all ones NV; -Inf FFF0_... -> 0 NV; min subnormal 0000_..._0001 RUP -> 1 NX.
//  Back-to-back 8 ops with out_ready toggled randomly: in-order results, tags match, outputs held while stalled,
//   in_ready low only when both stages full and out_ready=0.
//  Assert rst_n=0 for one cycle with 2 ops in flight -> out_valid=0 next cycle; no stale result after release.

Source files
------------

// File: rtl/fp_d_pkg.sv
// Shared double-precision constants and the stage-1 payload used by the FCVT.LU.D converter.
package fp_d_pkg;

    localparam int unsigned DP_EXP_W  = 11;
    localparam int unsigned DP_FRAC_W = 52;
    localparam int unsigned DP_BIAS   = 1023;
    localparam int unsigned U64_W     = 64;
    localparam int unsigned FFLAG_W   = 5;
    localparam int unsigned FFLAG_NV  = 4;
    localparam int unsigned FFLAG_NX  = 0;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam logic [U64_W-1:0] U64_MAX = '1;

    // Aligned operand handed from classify/align to round/saturate.
    typedef struct packed {
        logic             sign;
        logic             special_max;   // NaN or +Inf
        logic             special_neg;   // -Inf
        logic             overflow;      // |x| >= 2^64
        logic [U64_W-1:0] int_part;
        logic             guard;
        logic             sticky;
        logic [2:0]       rm;
    } cvt_s1_t;

endpackage

// File: rtl/fp_cvt_lu_d_round.sv
// Stage 2 of FCVT.LU.D: rounding increment, add, saturation and fflags.
module fp_cvt_lu_d_round
    import fp_d_pkg::*;
(
    input  cvt_s1_t            s1,
    output logic [U64_W-1:0]   lu_c,
    output logic [FFLAG_W-1:0] fflags_c
);

    logic             inexact;
    logic             inc;
    logic [U64_W-1:0] mag;

    // Select the increment for the rounding mode; reserved encodings behave as RNE.
    always_comb begin
        inexact = s1.guard | s1.sticky;
        inc     = 1'b0;
        case (s1.rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = s1.sign & inexact;
            RM_RUP:  inc = ~s1.sign & inexact;
            RM_RMM:  inc = s1.guard;
            default: inc = s1.guard & (s1.sticky | s1.int_part[0]);
        endcase
        mag = s1.int_part + U64_W'(inc);
    end

    // Apply specials/saturation; NV and NX are mutually exclusive.
    always_comb begin
        lu_c     = '0;
        fflags_c = '0;
        if (s1.special_max || (s1.overflow && !s1.sign)) begin
            lu_c               = U64_MAX;
            fflags_c[FFLAG_NV] = 1'b1;
        end else if (s1.special_neg || s1.overflow) begin
            fflags_c[FFLAG_NV] = 1'b1;
        end else if (s1.sign) begin
            if (mag != '0) begin
                fflags_c[FFLAG_NV] = 1'b1;
            end else begin
                fflags_c[FFLAG_NX] = inexact;
            end
        end else begin
            lu_c               = mag;
            fflags_c[FFLAG_NX] = inexact;
        end
    end

endmodule

// File: rtl/fp_cvt_lu_d_pipe.sv
// Two-stage valid/ready binary64 -> uint64 converter (RISC-V FCVT.LU.D).
module fp_cvt_lu_d_pipe
    import fp_d_pkg::*;
#(
    parameter int unsigned TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [63:0]        in_d,
    input  logic [2:0]         in_rm,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [63:0]        out_lu,
    output logic [4:0]         out_fflags,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int unsigned SH_W = 6;
    localparam logic [DP_EXP_W-1:0] EXP_MAX  = '1;
    localparam logic [DP_EXP_W-1:0] EXP_OVF  = DP_EXP_W'(DP_BIAS + U64_W);
    localparam logic [DP_EXP_W-1:0] EXP_LSH  = DP_EXP_W'(DP_BIAS + DP_FRAC_W);
    localparam logic [DP_EXP_W-1:0] EXP_ONE  = DP_EXP_W'(DP_BIAS);
    localparam logic [DP_EXP_W-1:0] EXP_HALF = DP_EXP_W'(DP_BIAS - 1);

    logic                  sign;
    logic [DP_EXP_W-1:0]   exp_f;
    logic [DP_FRAC_W-1:0]  frac;
    logic [U64_W-1:0]      mant;
    logic [SH_W-1:0]       lsh;
    logic [SH_W-1:0]       rsh;
    logic [2*U64_W-1:0]    ext;
    cvt_s1_t               cls;

    logic                  s1_valid;
    cvt_s1_t               s1_q;
    logic [TAG_W-1:0]      s1_tag;
    logic                  s2_load;
    logic [U64_W-1:0]      rnd_lu;
    logic [FFLAG_W-1:0]    rnd_fflags;

    // Output stage refills when empty or draining; input stage whenever it can pass its op on.
    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;

    // Stage 1: classify operand and align the significand to the integer point.
    always_comb begin
        sign  = in_d[63];
        exp_f = in_d[62:52];
        frac  = in_d[51:0];
        mant  = {(U64_W-DP_FRAC_W-1)'(0), 1'b1, frac};
        lsh   = SH_W'(exp_f - EXP_LSH);
        rsh   = SH_W'(EXP_LSH - exp_f);
        ext   = {mant, U64_W'(0)} >> rsh;

        cls      = '0;
        cls.sign = sign;
        cls.rm   = in_rm;
        if (exp_f == EXP_MAX) begin
            if (frac != '0 || !sign) cls.special_max = 1'b1;
            else                     cls.special_neg = 1'b1;
        end else if (exp_f == '0) begin
            cls.sticky = (frac != '0);
        end else if (exp_f >= EXP_OVF) begin
            cls.overflow = 1'b1;
        end else if (exp_f >= EXP_LSH) begin
            cls.int_part = mant << lsh;
        end else if (exp_f >= EXP_ONE) begin
            cls.int_part = ext[2*U64_W-1:U64_W];
            cls.guard    = ext[U64_W-1];
            cls.sticky   = |ext[U64_W-2:0];
        end else if (exp_f == EXP_HALF) begin
            cls.guard  = 1'b1;
            cls.sticky = (frac != '0);
        end else begin
            cls.sticky = 1'b1;
        end
    end

    // Stage 1 register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
            s1_tag   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q   <= cls;
                s1_tag <= in_tag;
            end
        end
    end

    fp_cvt_lu_d_round u_round (
        .s1       (s1_q),
        .lu_c     (rnd_lu),
        .fflags_c (rnd_fflags)
    );

    // Stage 2 / output register; contents held while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_lu     <= '0;
            out_fflags <= '0;
            out_tag    <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_lu     <= rnd_lu;
                out_fflags <= rnd_fflags;
                out_tag    <= s1_tag;
            end
        end
    end

endmodule
